// File: rtl/powlib_downfifo_pkt_if.sv
// powlib_downfifo_pkt_if: handshake bundle for the packet down-converting FIFO.
//   wrdata/wrcnt/wrlast/wrvld -> wide word in, with valid-lane count minus 1 and packet end
//   wrrdy                     <- block can accept a wide word
//   rddata/rdlast/rdvld       <- one narrow lane per beat, packet end on the final lane
//   rdrdy                     -> consumer takes the lane
//   master = producer/consumer side, slave = FIFO side.
interface powlib_downfifo_pkt_if #(
    parameter int W    = 16,
    parameter int MULT = 4,
    parameter int CW   = ($clog2(MULT) > 1) ? $clog2(MULT) : 1
);
    logic [W*MULT-1:0] wrdata;
    logic [CW-1:0]     wrcnt;
    logic              wrlast;
    logic              wrvld;
    logic              wrrdy;
    logic [W-1:0]      rddata;
    logic              rdlast;
    logic              rdvld;
    logic              rdrdy;
    modport master (
        output wrdata, wrcnt, wrlast, wrvld, rdrdy,
        input  wrrdy, rddata, rdlast, rdvld
    );
    modport slave (
        input  wrdata, wrcnt, wrlast, wrvld, rdrdy,
        output wrrdy, rddata, rdlast, rdvld
    );
endinterface

// File: rtl/powlib_downfifo_pkt.sv
// powlib_downfifo_pkt: packet-aware FIFO that buffers wide words and emits them one lane per beat.
//   clk     - single clock, rising edge
//   rst     - synchronous, active-low reset
//   bus     - slave modport: wide write handshake in, narrow lane handshake out
//   level_o - wide words held in the buffer, not counting the word in the serializer
module powlib_downfifo_pkt #(
    parameter int              W    = 16,
    parameter int              MULT = 4,
    parameter int              D    = 8,
    parameter int              MSBF = 0,
    parameter logic [8*16-1:0] ID   = "DOWNFIFOPKT",
    parameter int              EDBG = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    powlib_downfifo_pkt_if.slave   bus,
    output logic [$clog2(D+1)-1:0] level_o
);
    localparam int CW = ($clog2(MULT) > 1) ? $clog2(MULT) : 1;
    localparam int PW = $clog2(D);
    localparam int LW = $clog2(D+1);
    typedef enum logic {EMPTY, ACTIVE} state_t;
    logic [W*MULT-1:0] mem_data [D];
    logic [CW-1:0]     mem_cnt  [D];
    logic              mem_last [D];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              wrrdy_q;
    state_t            state_q, state_d;
    logic [W*MULT-1:0] data_q;
    logic [CW-1:0]     cnt_q, lane_q, lane_d, cnt_in, idx;
    logic              last_q;
    logic              push, load, nonempty, beat, last_lane;
    // ID/EDBG only name the instance for debug builds; no hardware depends on them.
    logic              unused_dbg;
    assign unused_dbg = ^{ID, EDBG};
    assign nonempty  = level_q != '0;
    assign push      = bus.wrvld && wrrdy_q;
    assign cnt_in    = (bus.wrcnt >= CW'(MULT-1)) ? CW'(MULT-1) : bus.wrcnt;
    assign beat      = state_q == ACTIVE && bus.rdrdy;
    assign last_lane = lane_q == cnt_q;
    // Serializer: on the final beat of a word the next word is loaded in the same cycle, so
    // back-to-back words stream without a bubble.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        load    = 1'b0;
        if (state_q == EMPTY) begin
            load    = nonempty;
            state_d = nonempty ? ACTIVE : EMPTY;
            lane_d  = '0;
        end else if (beat) begin
            load    = last_lane && nonempty;
            state_d = (last_lane && !nonempty) ? EMPTY : ACTIVE;
            lane_d  = last_lane ? '0 : lane_q + 1'b1;
        end
    end
    always_comb begin
        wptr_d  = push ? ((wptr_q == PW'(D-1)) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d  = load ? ((rptr_q == PW'(D-1)) ? '0 : rptr_q + 1'b1) : rptr_q;
        level_d = level_q + LW'(push) - LW'(load);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            wrrdy_q <= 1'b0;
            state_q <= EMPTY;
            lane_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            wrrdy_q <= level_d < LW'(D);
            state_q <= state_d;
            lane_q  <= lane_d;
            if (load) begin
                data_q <= mem_data[rptr_q];
                cnt_q  <= mem_cnt[rptr_q];
                last_q <= mem_last[rptr_q];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr_q] <= bus.wrdata;
            mem_cnt[wptr_q]  <= cnt_in;
            mem_last[wptr_q] <= bus.wrlast;
        end
    end
    // With MSBF the highest lane of the word is lane 0.
    assign idx        = (MSBF != 0) ? CW'(MULT-1) - lane_q : lane_q;
    assign bus.rddata = data_q[idx*W +: W];
    assign bus.rdvld  = state_q == ACTIVE;
    assign bus.rdlast = state_q == ACTIVE && last_q && last_lane;
    assign bus.wrrdy  = wrrdy_q;
    assign level_o    = level_q;
endmodule
